// File: rtl/flush_redirect_pkg.sv
// Shared encodings for the flush/redirect controller: flush causes, FSM states and a
// saturating increment used by the optional statistics counters.
package flush_redirect_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EX      = 2'd1,
        CAUSE_ERTN    = 2'd2,
        CAUSE_REFETCH = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == STAT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/inflight_counter.sv
// Up/down counter of in-flight instruction reads, bounded to [0, MAX_COUNT].
module inflight_counter #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Simultaneous inc/dec cancels; the bounds hold the value rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != MaxCnt)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

    overflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(inc_i && !dec_i && (count_q == MaxCnt)));

    underflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Central flush/redirect controller: kills all stages on a WB flush, drains stale instruction
// reads, then hands one redirect PC to IF. Optional statistics via FLUSH_REDIRECT_STATS_EN.
module flush_redirect_ctrl
    import flush_redirect_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic        wb_refetch,
    input  logic [31:0] wb_flush_entry,
    output logic        flush_all,
    output logic [1:0]  flush_cause,
`ifdef FLUSH_REDIRECT_STATS_EN
    output logic [31:0] stat_ex_cnt,
    output logic [31:0] stat_ertn_cnt,
    output logic [31:0] stat_refetch_cnt,
    output logic [31:0] stat_drain_cycles,
`endif
    input  logic        inst_req_fire,
    input  logic        inst_resp_fire,
    output logic        inst_req_allow,
    output logic        inst_resp_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    state_e           state_q;
    cause_e           cause;
    logic             flush_evt;
    logic [31:0]      target_q;
    logic [CNT_W-1:0] discard_cnt_q;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;

    assign flush_evt = wb_ex | wb_ertn | wb_refetch;

    always_comb begin
        cause = CAUSE_NONE;
        if (wb_ex) begin
            cause = CAUSE_EX;
        end else if (wb_ertn) begin
            cause = CAUSE_ERTN;
        end else if (wb_refetch) begin
            cause = CAUSE_REFETCH;
        end
    end

    assign flush_all   = flush_evt;
    assign flush_cause = cause;

    // A request handshaking in the flush cycle is still counted: arvalid cannot be retracted.
    inflight_counter #(
        .MAX_COUNT(MAX_OUTSTANDING),
        .CNT_W    (CNT_W)
    ) u_inflight (
        .clk         (clk),
        .resetn      (resetn),
        .inc_i       (inst_req_fire),
        .dec_i       (inst_resp_fire),
        .count_o     (outstanding),
        .count_next_o(outstanding_next)
    );

    assign inst_req_allow    = (state_q == ST_IDLE) && !flush_evt && (outstanding < MaxCnt);
    assign inst_resp_discard = inst_resp_fire &&
                               (((state_q == ST_IDLE) && flush_evt) || (state_q == ST_DRAIN));
    assign redirect_valid    = (state_q == ST_REDIRECT);
    assign redirect_pc       = target_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            target_q      <= 32'd0;
            discard_cnt_q <= '0;
        end else begin
            // Back-to-back WB flushes retarget the pending redirect without restarting it.
            if (flush_evt) begin
                target_q <= wb_flush_entry;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (flush_evt) begin
                        discard_cnt_q <= outstanding_next;
                        state_q       <= (outstanding_next != '0) ? ST_DRAIN : ST_REDIRECT;
                    end
                end
                ST_DRAIN: begin
                    if (inst_resp_fire) begin
                        discard_cnt_q <= discard_cnt_q - CNT_W'(1);
                        if (discard_cnt_q == CNT_W'(1)) begin
                            state_q <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FLUSH_REDIRECT_STATS_EN
    logic [31:0] stat_ex_q;
    logic [31:0] stat_ertn_q;
    logic [31:0] stat_refetch_q;
    logic [31:0] stat_drain_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_ex_q      <= 32'd0;
            stat_ertn_q    <= 32'd0;
            stat_refetch_q <= 32'd0;
            stat_drain_q   <= 32'd0;
        end else begin
            if (cause == CAUSE_EX) begin
                stat_ex_q <= sat_inc(stat_ex_q);
            end
            if (cause == CAUSE_ERTN) begin
                stat_ertn_q <= sat_inc(stat_ertn_q);
            end
            if (cause == CAUSE_REFETCH) begin
                stat_refetch_q <= sat_inc(stat_refetch_q);
            end
            if (state_q == ST_DRAIN) begin
                stat_drain_q <= sat_inc(stat_drain_q);
            end
        end
    end

    assign stat_ex_cnt       = stat_ex_q;
    assign stat_ertn_cnt     = stat_ertn_q;
    assign stat_refetch_cnt  = stat_refetch_q;
    assign stat_drain_cycles = stat_drain_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    drain_nonzero_a: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == ST_DRAIN) |-> (discard_cnt_q != '0));

    redirect_stable_a: assert property (@(posedge clk) disable iff (!resetn)
        ((state_q == ST_REDIRECT) && !redirect_ready && !flush_evt) |=> $stable(redirect_pc));

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Self-checking bench for flush_redirect_ctrl: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_flush_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_ex = 1'b0;
    logic        wb_ertn = 1'b0;
    logic        wb_refetch = 1'b0;
    logic [31:0] wb_flush_entry = 32'd0;
    logic        inst_req_fire = 1'b0;
    logic        inst_resp_fire = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush_all;
    logic [1:0]  flush_cause;
    logic        inst_req_allow;
    logic        inst_resp_discard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FLUSH_REDIRECT_STATS_EN
    logic [31:0] stat_ex_cnt;
    logic [31:0] stat_ertn_cnt;
    logic [31:0] stat_refetch_cnt;
    logic [31:0] stat_drain_cycles;
`endif

    always #5 clk = ~clk;

    flush_redirect_ctrl #(
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .wb_ex            (wb_ex),
        .wb_ertn          (wb_ertn),
        .wb_refetch       (wb_refetch),
        .wb_flush_entry   (wb_flush_entry),
        .flush_all        (flush_all),
        .flush_cause      (flush_cause),
`ifdef FLUSH_REDIRECT_STATS_EN
        .stat_ex_cnt      (stat_ex_cnt),
        .stat_ertn_cnt    (stat_ertn_cnt),
        .stat_refetch_cnt (stat_refetch_cnt),
        .stat_drain_cycles(stat_drain_cycles),
`endif
        .inst_req_fire    (inst_req_fire),
        .inst_resp_fire   (inst_resp_fire),
        .inst_req_allow   (inst_req_allow),
        .inst_resp_discard(inst_resp_discard),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    // Reference model: reads in flight, stale reads still to drop, redirect owed to IF.
    int          m_inflight = 0;
    int          m_drain = 0;
    bit          m_redir = 1'b0;
    logic [31:0] m_target = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_idle();
        return (m_drain == 0) && !m_redir;
    endfunction

    // Drive one cycle of inputs after the falling edge and check outputs against the model.
    task automatic apply(input logic ex, input logic ertn, input logic rf,
                         input logic [31:0] entry, input logic req, input logic resp,
                         input logic ready);
        bit   evt;
        int   exp_cause;
        bit   exp_allow;
        bit   exp_disc;
        @(negedge clk);
        wb_ex          = ex;
        wb_ertn        = ertn;
        wb_refetch     = rf;
        wb_flush_entry = entry;
        inst_req_fire  = req;
        inst_resp_fire = resp;
        redirect_ready = ready;
        #1;
        evt       = ex | ertn | rf;
        exp_cause = ex ? 1 : (ertn ? 2 : (rf ? 3 : 0));
        exp_allow = m_idle() && !evt && (m_inflight < 4);
        exp_disc  = resp && ((m_idle() && evt) || (m_drain > 0));
        check_eq("flush_all", 32'(flush_all), 32'(evt));
        check_eq("flush_cause", 32'(flush_cause), 32'(exp_cause));
        check_eq("inst_req_allow", 32'(inst_req_allow), 32'(exp_allow));
        check_eq("inst_resp_discard", 32'(inst_resp_discard), 32'(exp_disc));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        if (m_redir) check_eq("redirect_pc", redirect_pc, m_target);
        if (redirect_valid && redirect_ready) hs_cnt++;
    endtask

    task automatic tick();
        bit idle;
        bit evt;
        @(posedge clk);
        idle = m_idle();
        evt  = wb_ex | wb_ertn | wb_refetch;
        m_inflight = m_inflight + int'(inst_req_fire) - int'(inst_resp_fire);
        if (evt) m_target = wb_flush_entry;
        if (idle) begin
            if (evt) begin
                if (m_inflight > 0) m_drain = m_inflight;
                else m_redir = 1'b1;
            end
        end else if (m_drain > 0) begin
            if (inst_resp_fire) begin
                m_drain--;
                if (m_drain == 0) m_redir = 1'b1;
            end
        end else if (redirect_ready) begin
            m_redir = 1'b0;
        end
    endtask

    task automatic cyc(input logic ex, input logic ertn, input logic rf,
                       input logic [31:0] entry, input logic req, input logic resp,
                       input logic ready);
        apply(ex, ertn, rf, entry, req, resp, ready);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_flush_all"}, 32'(flush_all), 32'd0);
        check_eq({tag, "_cause"}, 32'(flush_cause), 32'd0);
        check_eq({tag, "_allow"}, 32'(inst_req_allow), 32'd1);
        check_eq({tag, "_discard"}, 32'(inst_resp_discard), 32'd0);
        check_eq({tag, "_rvalid"}, 32'(redirect_valid), 32'd0);
        check_eq({tag, "_rpc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        int  hs_before;
        bit  r_ex, r_ertn, r_rf, r_req, r_resp, r_rdy;
        logic [31:0] r_entry;

        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Exception with nothing in flight: immediate redirect, held until IF is ready.
        apply(0, 0, 0, 32'd0, 0, 0, 0);
        check_reset_outputs("reset");
        tick();
        apply(1, 0, 0, 32'h1c008000, 0, 0, 0);
        check_eq("ex_flush_all", 32'(flush_all), 32'd1);
        check_eq("ex_cause", 32'(flush_cause), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 32'd0, 0, 0, 0);
            check_eq("ex_rvalid_hold", 32'(redirect_valid), 32'd1);
            check_eq("ex_rpc_hold", redirect_pc, 32'h1c008000);
            tick();
        end
        cyc(0, 0, 0, 32'd0, 0, 0, 1);
        apply(0, 0, 0, 32'd0, 0, 0, 0);
        check_eq("ex_back_idle_rvalid", 32'(redirect_valid), 32'd0);
        check_eq("ex_back_idle_allow", 32'(inst_req_allow), 32'd1);
        tick();

        // Refetch with two reads outstanding: both responses dropped, then redirect.
        cyc(0, 0, 0, 32'd0, 1, 0, 0);
        cyc(0, 0, 0, 32'd0, 1, 0, 0);
        cyc(0, 0, 1, 32'h1c000104, 0, 0, 0);
        apply(0, 0, 0, 32'd0, 0, 1, 0);
        check_eq("rf_resp1_discard", 32'(inst_resp_discard), 32'd1);
        check_eq("rf_resp1_allow", 32'(inst_req_allow), 32'd0);
        tick();
        apply(0, 0, 0, 32'd0, 0, 1, 0);
        check_eq("rf_resp2_discard", 32'(inst_resp_discard), 32'd1);
        check_eq("rf_resp2_rvalid", 32'(redirect_valid), 32'd0);
        tick();
        apply(0, 0, 0, 32'd0, 0, 0, 0);
        check_eq("rf_rvalid", 32'(redirect_valid), 32'd1);
        check_eq("rf_rpc", redirect_pc, 32'h1c000104);
        tick();
        cyc(0, 0, 0, 32'd0, 0, 0, 1);

        // Ertn in the same cycle as a request and a response with one read outstanding.
        cyc(0, 0, 0, 32'd0, 1, 0, 0);
        apply(0, 1, 0, 32'h1c002000, 1, 1, 0);
        check_eq("ertn_same_discard", 32'(inst_resp_discard), 32'd1);
        check_eq("ertn_cause", 32'(flush_cause), 32'd2);
        tick();
        apply(0, 0, 0, 32'd0, 0, 0, 0);
        check_eq("ertn_drain_rvalid", 32'(redirect_valid), 32'd0);
        tick();
        apply(0, 0, 0, 32'd0, 0, 1, 0);
        check_eq("ertn_last_discard", 32'(inst_resp_discard), 32'd1);
        tick();
        apply(0, 0, 0, 32'd0, 0, 0, 1);
        check_eq("ertn_rpc", redirect_pc, 32'h1c002000);
        tick();

        // All three causes at once: exception wins.
        apply(1, 1, 1, 32'h1c003000, 0, 0, 0);
        check_eq("all3_cause", 32'(flush_cause), 32'd1);
        tick();
        apply(0, 0, 0, 32'd0, 0, 0, 1);
        check_eq("all3_rpc", redirect_pc, 32'h1c003000);
        tick();

        // Second exception while draining retargets; exactly one handshake follows.
        cyc(0, 0, 0, 32'd0, 1, 0, 0);
        cyc(1, 0, 0, 32'h1c009000, 0, 0, 0);
        apply(1, 0, 0, 32'h1c00A000, 0, 0, 0);
        check_eq("ex2_flush_all", 32'(flush_all), 32'd1);
        tick();
        cyc(0, 0, 0, 32'd0, 0, 1, 0);
        hs_before = hs_cnt;
        apply(0, 0, 0, 32'd0, 0, 0, 1);
        check_eq("ex2_rpc", redirect_pc, 32'h1c00A000);
        tick();
        repeat (4) cyc(0, 0, 0, 32'd0, 0, 0, 1);
        check_eq("ex2_one_handshake", 32'(hs_cnt - hs_before), 32'd1);

        // Five request attempts: only four fit, then reset lands mid-drain.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 32'd0, (m_idle() && m_inflight < 4), 0, 0);
        end
        apply(0, 0, 0, 32'd0, 0, 0, 0);
        check_eq("full_allow", 32'(inst_req_allow), 32'd0);
        tick();
        cyc(1, 0, 0, 32'h1c00B000, 0, 0, 0);
        cyc(0, 0, 0, 32'd0, 0, 1, 0);
        @(negedge clk);
        wb_ex = 0; wb_ertn = 0; wb_refetch = 0; wb_flush_entry = 0;
        inst_req_fire = 0; inst_resp_fire = 0; redirect_ready = 0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_inflight = 0; m_drain = 0; m_redir = 1'b0; m_target = 32'd0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic that respects the AXI/IF protocol.
        for (int i = 0; i < 3000; i++) begin
            r_ex    = ($urandom_range(11) == 0);
            r_ertn  = ($urandom_range(11) == 0);
            r_rf    = ($urandom_range(11) == 0);
            r_entry = $urandom;
            r_req   = m_idle() && (m_inflight < 4) && ($urandom_range(1) == 1);
            r_resp  = (m_inflight > 0) && ($urandom_range(2) == 0);
            r_rdy   = ($urandom_range(1) == 1);
            cyc(r_ex, r_ertn, r_rf, r_entry, r_req, r_resp, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Central flush/redirect controller between the WB stage, the fetch stage and the instruction-side AXI read channel.
- Takes WB exception, ertn and refetch flush requests and emits a same-cycle kill to all stages.
- Drains in-flight instruction reads whose data must be discarded, then presents one redirect PC to IF with a valid/ready handshake.
- While flushing, it blocks new fetch requests.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight instruction read requests (at least 1).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding and discard counters.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- wb_ex  in  1  WB exception taken this cycle (already qualified by WB valid).
- wb_ertn  in  1  WB ertn flush this cycle.
- wb_refetch  in  1  WB refetch flush (tlbwr/tlbfill/tlbrd/invtlb).
- wb_flush_entry  in  32  target PC computed by WB (CSR entry, ERA, or pc+4).
- flush_all  out  1  kill every stage's valid this cycle.
- flush_cause  out  2  cause of the accepted event: 0 none, 1 ex, 2 ertn, 3 refetch.
- inst_req_fire  in  1  arvalid & arready on the instruction channel.
- inst_resp_fire  in  1  rvalid & rready & rlast on the instruction channel.
- inst_req_allow  out  1  IF may raise a new arvalid.
- inst_resp_discard  out  1  IF must drop the returning read data this cycle.
- redirect_valid  out  1  redirect PC pending.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  IF accepts the redirect.

Behaviour:
- Reset: state=IDLE; outstanding=0; discard_cnt=0; target=0.
  - Outputs at reset: flush_all=0, flush_cause=0, inst_req_allow=1, inst_resp_discard=0, redirect_valid=0, redirect_pc=0.
- flush_evt = wb_ex | wb_ertn | wb_refetch.
- Priority: ex > ertn > refetch. flush_cause is combinational and equals 0 when flush_evt=0.
- flush_all = flush_evt, combinational and zero-latency in every state.
- Outstanding counter:
  - +1 on inst_req_fire, -1 on inst_resp_fire; both in one cycle means no change.
  - Counter is never allowed to exceed MAX_OUTSTANDING or drop below 0. A violation fires a simulation assertion.
- inst_req_allow = (state==IDLE) & ~flush_evt & (outstanding < MAX_OUTSTANDING).
- A req_fire already in progress during the event cycle is still counted, because AXI cannot retract arvalid.
- inst_resp_discard = inst_resp_fire & ((state==IDLE & flush_evt) | state==DRAIN).
- FSM:
  - IDLE, on flush_evt:
    - target <= wb_flush_entry.
    - n = outstanding + inst_req_fire - inst_resp_fire.
    - discard_cnt <= n.
    - Next state is DRAIN if n != 0, else REDIRECT.
  - DRAIN:
    - Each inst_resp_fire decrements discard_cnt.
    - When discard_cnt==1 and inst_resp_fire, go to REDIRECT next cycle.
  - REDIRECT:
    - redirect_valid=1, redirect_pc=target.
    - On redirect_ready, go to IDLE next cycle; redirect_valid drops the same edge.
    - redirect_pc holds stable while valid & ~ready.
- A flush_evt in DRAIN or REDIRECT (back-to-back WB event) overwrites target. The state is unchanged; flush_all still pulses.
- Only one redirect is ever issued per drain sequence.
- The first new arvalid can rise in the cycle after the redirect handshake.
- Reset asserted mid-sequence returns to IDLE immediately with all outputs at reset values. Any pending redirect is lost.

Optional Feature:
- Macro FLUSH_REDIRECT_STATS_EN.
- Defined:
  - Adds three 32-bit outputs: stat_ex_cnt, stat_ertn_cnt, stat_refetch_cnt, counting accepted flush_evt by flush_cause.
  - Adds one 32-bit output stat_drain_cycles, counting cycles spent in DRAIN.
  - All four counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package flush_redirect_pkg holds:
  - cause encodings CAUSE_NONE/EX/ERTN/REFETCH;
  - FSM state encoding ST_IDLE/ST_DRAIN/ST_REDIRECT;
  - the 2-bit typedefs for cause and state.
- One natural sub-module, inflight_counter: the parameterised up/down outstanding counter with overflow/underflow assertions.

Test Plan:
- Idle, outstanding=0, pulse wb_ex with entry 32'h1c008000:
  - flush_all=1 and cause=1 that cycle;
  - next cycle redirect_valid=1, redirect_pc=32'h1c008000;
  - hold ready low 3 cycles, pc stable; ready=1 returns to IDLE and inst_req_allow=1.
- Outstanding=2, wb_refetch with entry pc+4=32'h1c000104:
  - both following resp_fires have discard=1 and inst_req_allow=0 throughout;
  - redirect_valid rises the cycle after the 2nd response.
- Same-cycle wb_ertn + inst_req_fire + inst_resp_fire with outstanding=1:
  - that resp is discarded, discard_cnt=1, state DRAIN;
  - one more discarded resp, then redirect.
- wb_ex & wb_ertn & wb_refetch together: flush_cause=1, target = that cycle's wb_flush_entry.
- Second wb_ex in DRAIN with entry 32'h1c00A000: redirect_pc=32'h1c00A000 and only one redirect handshake occurs.
- Issue 5 req_fire with MAX_OUTSTANDING=4: inst_req_allow=0 at 4 outstanding. Then assert resetn=0 mid-DRAIN: all outputs return to reset values asynchronously.
